// File: rtl/tinyalu_cmd_master.sv
// -----------------------------------------------------------------------------
// tinyalu_cmd_master
// Command master sitting between a valid/ready command stream and a TinyALU
// style start/done core. One command at a time: it is accepted in IDLE,
// issued to the ALU (or short-circuited for no_op / illegal opcodes), and the
// result is presented on a valid/ready response port.
//
// Optional feature macro: TINYALU_MASTER_TIMEOUT_EN
//   When defined, an ISSUE cycle counter aborts a command that has waited
//   TIMEOUT_CYCLES start-high cycles without done, answering with rsp_err=1.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b         command opcode and operands
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_op, rsp_err  captured result, completed opcode, error flag
//   A, B, op, start              ALU operand/opcode/start (all registered)
//   done, result                 ALU completion and result
// -----------------------------------------------------------------------------
module tinyalu_cmd_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_err,
   output logic [7:0]  A,
   output logic [7:0]  B,
   output logic [2:0]  op,
   output logic        start,
   input  logic        done,
   input  logic [15:0] result
);

   typedef enum logic [1:0] {IDLE, ISSUE, NOP, RESP} state_t;

   state_t      state, state_d;
   logic        cmd_ready_d, start_d, rsp_valid_d, rsp_err_d;
   logic [7:0]  a_d, b_d;
   logic [2:0]  op_d, rsp_op_d;
   logic [15:0] rsp_result_d;

`ifdef TINYALU_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt, tmo_cnt_d;
`endif

   // Next-state and next-output logic. Every output is a flop; this block only
   // computes what each flop loads on the coming edge.
   always_comb begin
      // NOTE: every signal gets a hold default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state;
      start_d      = start;
      a_d          = A;
      b_d          = B;
      op_d         = op;
      rsp_valid_d  = rsp_valid;
      rsp_result_d = rsp_result;
      rsp_op_d     = rsp_op;
      rsp_err_d    = rsp_err;
`ifdef TINYALU_MASTER_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt;
`endif

      unique case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               rsp_op_d = cmd_op;
               unique case (cmd_op)
                  3'b000: state_d = NOP;
                  3'b001, 3'b010, 3'b011, 3'b100: begin
                     // Only legal ALU ops touch A/B/op; otherwise they hold.
                     a_d     = cmd_a;
                     b_d     = cmd_b;
                     op_d    = cmd_op;
                     start_d = 1'b1;
                     state_d = ISSUE;
`ifdef TINYALU_MASTER_TIMEOUT_EN
                     tmo_cnt_d = '0;
`endif
                  end
                  default: begin
                     rsp_valid_d  = 1'b1;
                     rsp_result_d = '0;
                     rsp_err_d    = 1'b1;
                     state_d      = RESP;
                  end
               endcase
            end
         end

         NOP: begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_err_d    = 1'b0;
            state_d      = RESP;
         end

         ISSUE: begin
            // done wins over a timeout that would expire on the same edge.
            if (done) begin
               rsp_result_d = result;
               start_d      = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_err_d    = 1'b0;
               state_d      = RESP;
            end
`ifdef TINYALU_MASTER_TIMEOUT_EN
            else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               rsp_result_d = '0;
               start_d      = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_err_d    = 1'b1;
               state_d      = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt + CW'(1);
            end
`endif
         end

         RESP: begin
            // Leaving RESP takes at least one cycle, which keeps start low
            // between consecutive ALU commands.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      cmd_ready_d = (state_d == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         start      <= 1'b0;
         A          <= '0;
         B          <= '0;
         op         <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_op     <= '0;
         rsp_err    <= 1'b0;
`ifdef TINYALU_MASTER_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         state      <= state_d;
         cmd_ready  <= cmd_ready_d;
         start      <= start_d;
         A          <= a_d;
         B          <= b_d;
         op         <= op_d;
         rsp_valid  <= rsp_valid_d;
         rsp_result <= rsp_result_d;
         rsp_op     <= rsp_op_d;
         rsp_err    <= rsp_err_d;
`ifdef TINYALU_MASTER_TIMEOUT_EN
         tmo_cnt    <= tmo_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_tinyalu_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_cmd_master
// Self-checking bench for tinyalu_cmd_master. An ALU model raises done on the
// 2nd start-high cycle for add/and/xor and the 5th for mul, and can inject
// stray done pulses while start is low. Expected responses come from a
// command-level reference (plain arithmetic on the issued opcode/operands).
// Define TINYALU_MASTER_TIMEOUT_EN to build with TIMEOUT_CYCLES=4 and run the
// hung-ALU scenario.
// -----------------------------------------------------------------------------
module tb_tinyalu_cmd_master;

`ifdef TINYALU_MASTER_TIMEOUT_EN
   localparam int TO_PARAM = 4;
   localparam int TMO_LIMIT = 4;
`else
   localparam int TO_PARAM = 16;
   localparam int TMO_LIMIT = 1 << 30;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_a, cmd_b;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic        rsp_err;
   logic [7:0]  A, B;
   logic [2:0]  op;
   logic        start;
   logic        done;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   bit alu_hang = 1'b0;
   bit noise_en = 1'b0;
   int alu_cnt  = 0;

   logic [7:0] last_a = '0, last_b = '0;
   logic [2:0] last_op = '0;

   tinyalu_cmd_master #(.TIMEOUT_CYCLES(TO_PARAM)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .A(A), .B(B), .op(op), .start(start),
      .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference ALU semantics.
   function automatic logic [15:0] ref_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      case (o)
         3'd1:    return 16'(a) + 16'(b);
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o);
      case (o)
         3'd1, 3'd2, 3'd3: return 2;
         3'd4:             return 5;
         default:          return 0;
      endcase
   endfunction

   // ALU model: counts start-high cycles and raises done on the latency-th
   // one; result carries garbage except while done is high.
   always @(posedge clk) begin
      #1;
      if (start) begin
         alu_cnt++;
         done   = !alu_hang && (alu_cnt == ref_lat(op));
         result = done ? ref_res(op, A, B) : 16'($urandom);
      end else begin
         alu_cnt = 0;
         done    = noise_en && ($urandom_range(0, 3) == 0);
         result  = 16'($urandom);
      end
   end

   task automatic accept(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      int guard = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = o; cmd_a = a; cmd_b = b;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("accept_wait", 32'(0), 32'(1));
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
   endtask

   task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input int hold);
      int lat, n_exp, n, guard;
      logic [15:0] res_exp;
      logic err_exp, legal;
      legal = (o >= 3'd1 && o <= 3'd4);
      lat   = alu_hang && legal ? TMO_LIMIT + 1 : ref_lat(o);
      if (lat > TMO_LIMIT) begin
         n_exp = TMO_LIMIT; err_exp = 1'b1; res_exp = 16'h0;
      end else begin
         n_exp = lat; err_exp = (o > 3'd4); res_exp = ref_res(o, a, b);
      end
      accept(o, a, b);
      if (legal) begin last_a = a; last_b = b; last_op = o; end
      n = 0; guard = 0;
      while (!rsp_valid && guard < 100) begin
         if (start) n++;
         check("alu_A",  32'(A),  32'(last_a));
         check("alu_B",  32'(B),  32'(last_b));
         check("alu_op", 32'(op), 32'(last_op));
         check("busy_ready", 32'(cmd_ready), 32'(0));
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("rsp_wait", 32'(0), 32'(1));
      check("start_cycles", 32'(n), 32'(n_exp));
      check("start_low_in_resp", 32'(start), 32'(0));
      for (int i = 0; i <= hold; i++) begin
         check("rsp_valid",  32'(rsp_valid),  32'(1));
         check("rsp_result", 32'(rsp_result), 32'(res_exp));
         check("rsp_op",     32'(rsp_op),     32'(o));
         check("rsp_err",    32'(rsp_err),    32'(err_exp));
         check("resp_ready", 32'(cmd_ready),  32'(0));
         if (i == hold) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      check("rsp_cleared", 32'(rsp_valid), 32'(0));
      check("idle_ready",  32'(cmd_ready), 32'(1));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"},     32'(start),      32'(0));
      check({tag, "_A"},         32'(A),          32'(0));
      check({tag, "_B"},         32'(B),          32'(0));
      check({tag, "_op"},        32'(op),         32'(0));
      check({tag, "_rsp_valid"}, 32'(rsp_valid),  32'(0));
      check({tag, "_rsp_result"},32'(rsp_result), 32'(0));
      check({tag, "_rsp_op"},    32'(rsp_op),     32'(0));
      check({tag, "_rsp_err"},   32'(rsp_err),    32'(0));
      check({tag, "_cmd_ready"}, 32'(cmd_ready),  32'(0));
   endtask

   task automatic reset_mid_mul();
      int n = 0, guard = 0;
      accept(3'd4, 8'h12, 8'h34);
      while (n < 3 && guard < 20) begin
         if (start) n++;
         if (n < 3) @(negedge clk);
         guard++;
      end
      check("mul_3rd_cycle", 32'(n), 32'(3));
      reset_n = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      reset_n = 1'b1;
      last_a = '0; last_b = '0; last_op = '0;
      @(negedge clk);
      check("midrst_ready", 32'(cmd_ready), 32'(1));
      for (int i = 0; i < 8; i++) begin
         check("midrst_no_rsp", 32'(rsp_valid | start), 32'(0));
         @(negedge clk);
      end
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      rsp_ready = 1'b0; done = 1'b0; result = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(cmd_ready), 32'(1));

      run_cmd(3'd1, 8'h0F, 8'h01, 0);   // add
      run_cmd(3'd4, 8'hFF, 8'hFF, 0);   // mul
      run_cmd(3'd0, 8'h77, 8'h88, 0);   // no_op
      run_cmd(3'd6, 8'h11, 8'h22, 1);   // illegal
      run_cmd(3'd3, 8'hAA, 8'h55, 3);   // xor with backpressure
      reset_mid_mul();

      noise_en = 1'b1;
      for (int k = 0; k < 40; k++)
         run_cmd(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

`ifdef TINYALU_MASTER_TIMEOUT_EN
      alu_hang = 1'b1;
      run_cmd(3'd1, 8'h01, 8'h02, 2);
      alu_hang = 1'b0;
      run_cmd(3'd2, 8'hF0, 8'h3C, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tinyalu_cmd_master.md
TINYALU_CMD_MASTER -- requirements
Module: tinyalu_cmd_master

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-low on reset_n.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of start-high cycles without done (used only when TINYALU_MASTER_TIMEOUT_EN is defined).
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  master can accept a command
- cmd_op  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream accepts response
- rsp_result  out  16  captured result
- rsp_op  out  3  opcode of the completed command
- rsp_err  out  1  illegal opcode or timeout
- A  out  8  ALU operand A
- B  out  8  ALU operand B
- op  out  3  ALU opcode
- start  out  1  ALU start
- done  in  1  ALU done
- result  in  16  ALU result

Function
REQ-004 The block SHALL be a registered FSM with states IDLE, ISSUE, NOP and RESP; all outputs SHALL be driven from flops.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-006 For a legal op 001–100, acceptance at edge T SHALL load A, B and op and set start=1 from T+1, with the FSM in ISSUE.
REQ-007 In ISSUE, start, A, B and op SHALL stay constant until done is sampled 1.
REQ-008 On the edge where done=1 is sampled in ISSUE, the block SHALL:
- capture result into rsp_result
- clear start
- set rsp_valid=1, rsp_err=0
- enter RESP
REQ-009 For op 000, the block SHALL NOT assert start; it SHALL enter NOP for one cycle, then RESP with rsp_result=0 and rsp_err=0.
REQ-010 For ops 101–111, the block SHALL NOT assert start; it SHALL enter RESP on the next edge with rsp_result=0 and rsp_err=1.
REQ-011 In RESP, rsp_valid, rsp_result, rsp_op and rsp_err SHALL stay constant until rsp_ready=1; the FSM SHALL then return to IDLE and clear rsp_valid on the same edge.
REQ-012 start SHALL be low for at least one cycle between consecutive ALU commands; RESP guarantees this.
REQ-013 done sampled outside ISSUE SHALL be ignored and SHALL NOT change any output.
REQ-014 If done=1 is sampled on the first start-high cycle, the block SHALL complete normally per REQ-008.
REQ-015 A, B and op SHALL hold their last values when start=0; only start qualifies them.

Reset
REQ-016 While reset_n=0 at a clk edge, the block SHALL set:
- state=IDLE
- start=0, A=0, B=0, op=0
- rsp_valid=0, rsp_result=0, rsp_op=0, rsp_err=0
- cmd_ready=0, then 1 on the first edge with reset_n=1
REQ-017 A reset during ISSUE or RESP SHALL drop start on that edge and discard the in-flight command with no response.

Configuration
REQ-018 With macro TINYALU_MASTER_TIMEOUT_EN defined:
- a counter SHALL count ISSUE cycles
- if TIMEOUT_CYCLES cycles elapse without done, the block SHALL clear start and enter RESP with rsp_result=0 and rsp_err=1
- a done arriving afterwards SHALL be ignored
REQ-019 Without TINYALU_MASTER_TIMEOUT_EN, the counter SHALL NOT exist, ISSUE SHALL wait indefinitely, and rsp_err SHALL be set only by illegal opcodes.

Verification
REQ-020 The bench SHALL cover these directed scenarios, with an ALU model that asserts done on the 2nd start-high cycle for add/and/xor and the 5th for mul:
- add A=8'h0F, B=8'h01, rsp_ready=1: start high for 2 cycles; rsp_result=16'h0010, rsp_err=0; start low ≥1 cycle before the next command.
- mul A=8'hFF, B=8'hFF: start high for 5 cycles with A, B, op stable; rsp_result=16'hFE01.
- cmd_op=000, then cmd_op=110: start never rises; responses are (result 0, err 0) and then (result 0, err 1).
- xor 8'hAA^8'h55 with rsp_ready held 0 for 3 cycles: rsp_valid and rsp_result=16'h00FF stable; cmd_ready=0 until rsp_ready=1.
- reset_n=0 during the 3rd start-high cycle of a mul: start=0 and all outputs 0 on the next edge; no response is emitted.
- With TINYALU_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, an ALU that never asserts done: start falls after 4 cycles; rsp_err=1, rsp_result=0.
